// File: rtl/byte_rr_arbiter.sv
// Packet-aware round-robin arbiter: NUM_REQ valid/ready/last byte streams share
// one registered output stage; a grant is held until the owner's last beat.
module byte_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [ID_W-1:0]           out_id,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic                      busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [ID_W-1:0]   owner, owner_d;
    logic [ID_W-1:0]   rr_ptr, rr_ptr_d;
    logic              load_en;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     scan_idx;
    logic              xfer;
    logic [ID_W-1:0]   xfer_id;
    logic [DATA_W-1:0] xfer_data;

    logic              vld_p0;
    logic [DATA_W-1:0] out_data_p0;
    logic [ID_W-1:0]   out_id_p0;
    logic              out_last_p0;

    function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
        if (p == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign load_en = !vld_p0 || out_ready;

    // Rotating priority scan; one extra bit keeps rr_ptr+k from overflowing.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (scan_idx >= (ID_W + 1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W + 1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state;
        owner_d   = owner;
        rr_ptr_d  = rr_ptr;
        req_ready = '0;
        xfer      = 1'b0;
        xfer_id   = '0;
        case (state)
            IDLE: begin
                if (load_en && grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    xfer    = 1'b1;
                    xfer_id = grant_idx;
                    if (req_last[grant_idx]) begin
                        rr_ptr_d = ptr_inc(grant_idx);
                    end else begin
                        state_d = LOCKED;
                        owner_d = grant_idx;
                    end
                end
            end
            LOCKED: begin
                if (load_en && req_valid[owner]) begin
                    req_ready[owner] = 1'b1;
                    xfer    = 1'b1;
                    xfer_id = owner;
                    if (req_last[owner]) begin
                        state_d  = IDLE;
                        rr_ptr_d = ptr_inc(owner);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Nothing may be accepted while reset is asserted.
        if (!rst_n) begin
            req_ready = '0;
            xfer      = 1'b0;
        end
    end

    assign xfer_data = req_data[xfer_id*DATA_W +: DATA_W];

    // Stage p0: arbitration state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_d;
            owner  <= owner_d;
            rr_ptr <= rr_ptr_d;
        end
    end

    // Stage p0: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0      <= 1'b0;
            out_data_p0 <= '0;
            out_id_p0   <= '0;
            out_last_p0 <= 1'b0;
        end else if (xfer) begin
            vld_p0      <= 1'b1;
            out_data_p0 <= xfer_data;
            out_id_p0   <= xfer_id;
            out_last_p0 <= req_last[xfer_id];
        end else if (out_ready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = out_data_p0;
    assign out_id    = out_id_p0;
    assign out_last  = out_last_p0;
    assign busy      = (state == LOCKED);

endmodule

// File: tb/tb_byte_rr_arbiter.sv
// Scoreboard bench for byte_rr_arbiter: directed requester streams, expected
// beats queued in hand-computed grant order, a forked monitor pops on each drain.
module tb_byte_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;
    logic                      out_last;
    logic                      out_ready;
    logic                      busy;

    always #5 clk = ~clk;

    byte_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    logic [8:0]         src_mem [NUM_REQ][16];
    int                 head [NUM_REQ];
    int                 tail [NUM_REQ];
    logic [NUM_REQ-1:0] en_mask;
    logic [10:0]        exp_q [$];
    int                 passed = 0;
    int                 total  = 0;
    logic [NUM_REQ-1:0] ready_s;
    logic               busy_s;
    logic               ovalid_s;
    logic [DATA_W-1:0]  data_s;
    int                 heads_before;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push_src(input int r, input logic [7:0] d, input logic l);
        src_mem[r][tail[r]] = {d, l};
        tail[r]++;
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [7:0] d, input logic l);
        exp_q.push_back({d, id, l});
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (en_mask[i] && head[i] < tail[i]) begin
                req_valid[i]                 = 1'b1;
                req_data[i*DATA_W +: DATA_W] = src_mem[i][head[i]][8:1];
                req_last[i]                  = src_mem[i][head[i]][0];
            end else begin
                req_valid[i]                 = 1'b0;
                req_data[i*DATA_W +: DATA_W] = '0;
                req_last[i]                  = 1'b0;
            end
        end
    endtask

    // One clock: sample at negedge, retire accepted beats at posedge, redrive.
    task automatic cycle();
        logic [NUM_REQ-1:0] v;
        @(negedge clk);
        ready_s  = req_ready;
        busy_s   = busy;
        ovalid_s = out_valid;
        data_s   = out_data;
        v        = req_valid;
        check("ready_onehot", 32'($countones(ready_s) <= 1), 32'd1);
        @(posedge clk);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i] && ready_s[i]) head[i]++;
        end
        #1 drive();
    endtask

    task automatic monitor_loop();
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {21'd0, out_data, out_id, out_last}, 32'h7ff);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {21'd0, out_data, out_id, out_last}, {21'd0, e});
                end
            end
        end
    endtask

    function automatic int heads_sum();
        int s = 0;
        for (int i = 0; i < NUM_REQ; i++) s += head[i];
        return s;
    endfunction

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        out_ready = 1'b1;
        en_mask   = 4'b1111;
        // Reset with all four requesting, then fairness: two single-beat rounds
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                push_src(i, 8'(r * 4 + i), 1'b1);
                push_exp(2'(i), 8'(r * 4 + i), 1'b1);
            end
        end
        drive();
        fork
            monitor_loop();
        join_none
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_id", 32'(out_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        heads_before = heads_sum();
        cycle();
        check("first_grant", 32'(ready_s), 32'h1);
        repeat (7) cycle();
        check("throughput", 32'(heads_sum() - heads_before), 32'd8);

        // Packet lock on requester 2, then rotation continues at 3
        push_src(2, 8'hA0, 1'b0); push_src(2, 8'hA1, 1'b0); push_src(2, 8'hA2, 1'b1);
        push_src(0, 8'hB0, 1'b1); push_src(1, 8'hC0, 1'b1); push_src(3, 8'hD0, 1'b1);
        push_exp(2, 8'hA0, 0); push_exp(2, 8'hA1, 0); push_exp(2, 8'hA2, 1);
        push_exp(3, 8'hD0, 1); push_exp(0, 8'hB0, 1); push_exp(1, 8'hC0, 1);
        en_mask = 4'b0100;
        drive();
        cycle();
        check("lock_grant0", 32'(ready_s), 32'h4);
        check("lock_busy0", 32'(busy_s), 32'h0);
        en_mask = 4'b1111;
        drive();
        for (int k = 0; k < 2; k++) begin
            cycle();
            check("lock_grant", 32'(ready_s), 32'h4);
            check("lock_busy", 32'(busy_s), 32'h1);
        end
        cycle();
        check("after_lock_grant", 32'(ready_s), 32'h8);
        check("after_lock_busy", 32'(busy_s), 32'h0);
        cycle();
        check("rr_grant0", 32'(ready_s), 32'h1);
        cycle();
        check("rr_grant1", 32'(ready_s), 32'h2);

        // Owner stall: requester 1 goes quiet mid-packet
        push_src(1, 8'hE0, 1'b0); push_src(1, 8'hE1, 1'b0); push_src(1, 8'hE2, 1'b1);
        push_exp(1, 8'hE0, 0); push_exp(1, 8'hE1, 0); push_exp(1, 8'hE2, 1);
        push_exp(2, 8'h9A, 1); push_exp(3, 8'h9B, 1); push_exp(0, 8'h9C, 1);
        en_mask = 4'b0010;
        drive();
        cycle();
        check("stall_grant0", 32'(ready_s), 32'h2);
        push_src(0, 8'h9C, 1'b1); push_src(2, 8'h9A, 1'b1); push_src(3, 8'h9B, 1'b1);
        en_mask = 4'b1101;
        drive();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("stall_ready", 32'(ready_s), 32'h0);
            check("stall_busy", 32'(busy_s), 32'h1);
        end
        en_mask = 4'b1111;
        drive();
        cycle();
        check("resume_grant1", 32'(ready_s), 32'h2);
        cycle();
        check("resume_grant2", 32'(ready_s), 32'h2);
        repeat (3) cycle();

        // Backpressure: output held for 4 cycles
        push_src(1, 8'h51, 1'b1); push_src(2, 8'h52, 1'b1); push_src(3, 8'h53, 1'b1);
        push_exp(1, 8'h51, 1); push_exp(2, 8'h52, 1); push_exp(3, 8'h53, 1);
        drive();
        cycle();
        check("bp_grant", 32'(ready_s), 32'h2);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("bp_ready", 32'(ready_s), 32'h0);
            check("bp_valid", 32'(ovalid_s), 32'h1);
            check("bp_data", 32'(data_s), 32'h51);
        end
        out_ready = 1'b1;
        cycle();
        check("bp_release0", 32'(ready_s), 32'h4);
        cycle();
        check("bp_release1", 32'(ready_s), 32'h8);

        // Async reset mid-packet with rr_ptr away from 0
        push_src(1, 8'h61, 1'b1);
        push_src(3, 8'h70, 1'b0); push_src(3, 8'h71, 1'b0); push_src(3, 8'h72, 1'b1);
        push_exp(1, 8'h61, 1); push_exp(3, 8'h70, 0);
        drive();
        cycle();
        check("ar_grant_r1", 32'(ready_s), 32'h2);
        cycle();
        check("ar_grant_r3", 32'(ready_s), 32'h8);
        cycle();
        check("ar_locked", 32'(busy_s), 32'h1);
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'h0);
        check("ar_busy", 32'(busy), 32'h0);
        check("ar_req_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < NUM_REQ; i++) head[i] = tail[i];
        push_src(0, 8'h80, 1'b1); push_src(2, 8'h82, 1'b1);
        push_exp(0, 8'h80, 1); push_exp(2, 8'h82, 1);
        #1;
        rst_n = 1'b1;
        drive();
        cycle();
        check("ar_ptr_restart", 32'(ready_s), 32'h1);
        cycle();
        check("ar_next", 32'(ready_s), 32'h4);
        repeat (3) cycle();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
